// File: rtl/seven_seg_pkg.sv
// Shared definitions for the two-digit seven-segment interface: segment codes,
// bus width and the capture FSM state encoding.
package seven_seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  typedef enum logic [0:0] {
    WAIT = 1'b0,
    PEND = 1'b1
  } cap_state_t;

endpackage

// File: rtl/seven_seg_digit_decode.sv
// Combinational decode of one active-high segment pattern to a BCD digit.
// Any pattern outside the ten digit codes reports legal=0 with digit 0.
module seven_seg_digit_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [3:0]       digit,
  output logic             legal
);

  // Pattern lookup; the default arm flags illegal codes
  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: begin
        digit = 4'd0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Debounced two-digit seven-segment receiver with a valid/ready output.
// Option: define SEVEN_SEG_CAPTURE_BLANK_EN to accept a blank tens digit as 0.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] seg_a,
  input  logic [SEG_W-1:0] seg_b,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [6:0]       out_value,
  output logic             out_err
);

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

  logic [2*SEG_W-1:0] sample_s;
  logic [2*SEG_W-1:0] last_sample_r;
  logic [2*SEG_W-1:0] last_emitted_r;
  logic [3:0]         cnt_r;
  logic               have_emitted_r;
  cap_state_t         state_r;

  logic [3:0] tens_digit_s;
  logic       tens_legal_s;
  logic [3:0] ones_digit_s;
  logic       ones_legal_s;
  logic [3:0] tens_val_s;
  logic       tens_ok_s;
  logic [6:0] value_s;
  logic       err_s;
  logic       stable_s;
  logic       fresh_s;

  assign sample_s = {seg_a, seg_b};
  assign stable_s = (cnt_r == STABLE_CNT);
  assign fresh_s  = !have_emitted_r || (last_sample_r != last_emitted_r);

  seven_seg_digit_decode u_dec_tens (
    .seg   (last_sample_r[2*SEG_W-1:SEG_W]),
    .digit (tens_digit_s),
    .legal (tens_legal_s)
  );

  seven_seg_digit_decode u_dec_ones (
    .seg   (last_sample_r[SEG_W-1:0]),
    .digit (ones_digit_s),
    .legal (ones_legal_s)
  );

  // Combine both digits into tens*10+ones; any illegal digit forces 0 with err
  always_comb begin
    tens_val_s = tens_digit_s;
    tens_ok_s  = tens_legal_s;
`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
    if (last_sample_r[2*SEG_W-1:SEG_W] == SEG_BLANK) begin
      tens_val_s = 4'd0;
      tens_ok_s  = 1'b1;
    end else begin
      tens_val_s = tens_digit_s;
      tens_ok_s  = tens_legal_s;
    end
`endif
    if (tens_ok_s && ones_legal_s) begin
      err_s   = 1'b0;
      value_s = {tens_val_s, 3'b000} + {2'b00, tens_val_s, 1'b0} + {3'b000, ones_digit_s};
    end else begin
      err_s   = 1'b1;
      value_s = 7'd0;
    end
  end

  // Input sampler: restart the stability count on any change, saturate at the threshold
  always_ff @(posedge clk) begin
    if (rst) begin
      last_sample_r <= '0;
      cnt_r         <= 4'd0;
    end else if (sample_s != last_sample_r) begin
      last_sample_r <= sample_s;
      cnt_r         <= 4'd1;
    end else if (cnt_r < STABLE_CNT) begin
      cnt_r         <= cnt_r + 4'd1;
    end
  end

  // Output FSM: capture a stable, not-yet-emitted pattern and hold it until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= WAIT;
      out_valid      <= 1'b0;
      out_value      <= 7'd0;
      out_err        <= 1'b0;
      last_emitted_r <= '0;
      have_emitted_r <= 1'b0;
    end else begin
      case (state_r)
        WAIT: begin
          if (stable_s && fresh_s) begin
            out_value      <= value_s;
            out_err        <= err_s;
            out_valid      <= 1'b1;
            last_emitted_r <= last_sample_r;
            have_emitted_r <= 1'b1;
            state_r        <= PEND;
          end
        end
        PEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= WAIT;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= WAIT;
        end
      endcase
    end
  end

endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Receive side of the two-digit seven-segment interface. The block samples the tens and ones segment buses and waits until the pattern has been stable for a configurable number of cycles. It then decodes the pattern back to a binary value and presents it once on a valid/ready output. It sits after the segment encoder in self-checking loops and feeds the adder/result comparison path.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- seg_a  input  7  tens-digit segments, active-high, bit0=a … bit6=g.
- seg_b  input  7  ones-digit segments, same encoding.
- out_ready  input  1  consumer accepts the output this cycle.
- out_valid  output  1  decoded value pending.
- out_value  output  7  tens*10+ones, range 0..99.
- out_err  output  1  pending value came from an illegal pattern.

## Operation
- Digit codes: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. Any other code is illegal.
- Sampling runs every cycle:
  - last_sample holds {seg_a,seg_b}.
  - If the input differs from last_sample: last_sample <= input and cnt <= 1.
  - Else if cnt < STABLE_CYCLES: cnt increments.
  - The pattern is stable when cnt == STABLE_CYCLES.
- FSM states:
  - WAIT: out_valid=0. If the pattern is stable and either (have_emitted==0) or (last_sample != last_emitted):
    - Decode last_sample into out_value/out_err.
    - last_emitted <= last_sample and have_emitted <= 1.
    - Go to PEND.
  - PEND: out_valid=1, and out_value/out_err are held constant. On out_ready=1 go to WAIT.
  - Sampling continues in PEND. Input changes never alter the pending value.
- A pattern held unchanged produces exactly one transfer.
- Illegal pattern (either digit): out_err=1 and out_value=0. It is still emitted once and still recorded as last_emitted.
- Arithmetic: out_value = tens*10 + ones, computed in 7 bits. No overflow is possible.
- Reset values: out_valid=0, out_value=0, out_err=0, cnt=0, last_sample=0, last_emitted=0, have_emitted=0, state=WAIT.
- Reset asserted in PEND discards the pending value. No transfer completes on a reset cycle.

## Timing
- Latency: if a new pattern is first sampled at edge 1, cnt reaches STABLE_CYCLES at edge STABLE_CYCLES. out_valid is high after edge STABLE_CYCLES+1.
- The transfer completes on an edge with out_valid=1 and out_ready=1. out_valid is low in the following cycle.
- Maximum throughput is one transfer per 2 cycles.
- A change on either bus before cnt reaches STABLE_CYCLES restarts the count at 1.
- Change and accept on the same edge: the accept completes, and the new pattern starts its own count.
- out_ready is ignored while out_valid=0.

## Configuration
- SEVEN_SEG_CAPTURE_BLANK_EN defined: seg_a == 0x00 (all segments off) decodes as tens digit 0. This allows leading-zero blanking. seg_b == 0x00 remains illegal.
- Not defined: seg_a == 0x00 is illegal (out_err=1).

## Structure
- Shared package seven_seg_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK constants;
  - the segment bus width (7);
  - the capture FSM state encoding (WAIT, PEND).
- Sub-module seven_seg_digit_decode: combinational, 7-bit pattern in, 4-bit digit plus legal flag out. It is instantiated once per digit. The blank option is handled in the top level, tens digit only.

## Test plan
- Reset, then seg_a=0x06, seg_b=0x5B held, out_ready=1 → out_valid high after edge 5, out_value=12, out_err=0. Exactly one transfer over the following 20 cycles.
- seg_b=0x5B for 2 cycles, then 0x4F held with seg_a=0x06 → no output until 4 stable samples of 0x4F, then out_value=13.
- Accept 12, then switch to seg_a=0x3F, seg_b=0x3F → out_value=0, out_err=0. Switching back to 0x06/0x5B emits 12 again.
- seg_a=0x3F, seg_b=0x01 → out_err=1, out_value=0, emitted once.
- out_ready=0 with 12 pending, input changed to 0x6F/0x6F → value stays 12 until ready. The cycle after the accept is low; 99 is then emitted.
- seg_a=0x00, seg_b=0x4F → out_value=3 and out_err=0 with SEVEN_SEG_CAPTURE_BLANK_EN; out_err=1 and out_value=0 without it.
